gps_ca_acquire: RTL

- Receiver-side counterpart to the GPS C/A code generator.
- Accepts a serial C/A chip stream for one satellite (PRN 1..32).
- Runs a local Gold-code replica and slides its phase one chip at a time until epoch correlation crosses a lock threshold.
- Once locked, keeps verifying every epoch and reports lock phase and correlation counts; used as the checker/acquisition stage downstream of the code generator.

---
 rtl/gps_pkg.sv | 33 +++
 rtl/gps_ca_gen.sv | 61 ++++++
 rtl/gps_ca_acquire.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gps_pkg.sv
// Shared GPS C/A definitions: code length, G2 phase-selector taps, acquisition states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package gps_pkg;

    localparam int CA_LEN = 1023;

    // Pair of G2 stage indices (1..10) XORed to form the delayed G2 output
    typedef struct packed {
        logic [3:0] t1;
        logic [3:0] t2;
    } g2_taps_t;

    // Entry 0 is PRN 1
    localparam g2_taps_t G2_TAPS [32] = '{
        '{4'd2, 4'd6},  '{4'd3, 4'd7},  '{4'd4, 4'd8},  '{4'd5, 4'd9},
        '{4'd1, 4'd9},  '{4'd2, 4'd10}, '{4'd1, 4'd8},  '{4'd2, 4'd9},
        '{4'd3, 4'd10}, '{4'd2, 4'd3},  '{4'd3, 4'd4},  '{4'd5, 4'd6},
        '{4'd6, 4'd7},  '{4'd7, 4'd8},  '{4'd8, 4'd9},  '{4'd9, 4'd10},
        '{4'd1, 4'd4},  '{4'd2, 4'd5},  '{4'd3, 4'd6},  '{4'd4, 4'd7},
        '{4'd5, 4'd8},  '{4'd6, 4'd9},  '{4'd1, 4'd3},  '{4'd4, 4'd6},
        '{4'd5, 4'd7},  '{4'd6, 4'd8},  '{4'd7, 4'd9},  '{4'd8, 4'd10},
        '{4'd1, 4'd6},  '{4'd2, 4'd7},  '{4'd3, 4'd8},  '{4'd4, 4'd9}
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_SLIP   = 2'd2,
        ST_TRACK  = 2'd3
    } state_e;

endpackage

// File: rtl/gps_ca_gen.sv
// C/A Gold-code replica: G1/G2 LFSRs with PRN-selected G2 phase taps.
// Latency: chip_o is combinational from the current register state.
// Backpressure: none; state moves only on adv_i, returns to all ones after 1023 advances.
module gps_ca_gen
    import gps_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       reload_i,
    input  logic       adv_i,
    input  logic [4:0] prn_idx_i,
    output logic       chip_o
);

    logic [10:1] g1_q, g1_d;
    logic [10:1] g2_q, g2_d;
    logic [9:0]  cnt_q, cnt_d;
    g2_taps_t    taps;

    // Select the PRN's tap pair and form the output chip
    always_comb begin
        taps   = G2_TAPS[prn_idx_i];
        chip_o = g1_q[10] ^ g2_q[taps.t1] ^ g2_q[taps.t2];
    end

    // Next-state: reload, wrap at end of code period, or shift both LFSRs
    always_comb begin
        g1_d  = g1_q;
        g2_d  = g2_q;
        cnt_d = cnt_q;
        if (reload_i) begin
            g1_d  = '1;
            g2_d  = '1;
            cnt_d = '0;
        end else if (adv_i) begin
            if (cnt_q == 10'(CA_LEN - 1)) begin
                g1_d  = '1;
                g2_d  = '1;
                cnt_d = '0;
            end else begin
                g1_d  = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
                g2_d  = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
                cnt_d = cnt_q + 10'd1;
            end
        end
    end

    // Generator state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            g1_q  <= '1;
            g2_q  <= '1;
            cnt_q <= '0;
        end else begin
            g1_q  <= g1_d;
            g2_q  <= g2_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gps_ca_acquire.sv
// Serial C/A code acquisition: slides a local replica one chip per failed epoch until lock.
// Latency: epoch result (corr_valid/corr_count/locked) registered one cycle after the 1023rd chip.
// Backpressure: none; chip_valid=0 cycles simply stall the search.
module gps_ca_acquire
    import gps_pkg::*;
#(
    parameter int LOCK_THRESH = 1000,
    parameter int LOSS_THRESH = 900,
    parameter int MAX_SLIPS   = 1023
) (
    input  logic        sys_clk_50,
    input  logic        sync_rst_in,
    input  logic [5:0]  sv_num,
    input  logic        start,
    input  logic        chip_valid,
    input  logic        chip_in,
    output logic        busy,
    output logic        locked,
    output logic [9:0]  lock_phase,
    output logic        corr_valid,
    output logic [10:0] corr_count,
    output logic        search_fail
);

    state_e      state_q;
    logic [4:0]  prn_q, prn_d;
    logic [9:0]  epoch_q;
    logic [10:0] match_q, match_d;
    logic [9:0]  slip_q;
    logic        busy_q, locked_q, corr_vld_q, fail_q;
    logic [9:0]  phase_q;
    logic [10:0] corr_cnt_q;

    logic        sv_ok, in_corr, epoch_end;
    logic        gen_adv, gen_reload, local_chip;

    // Start qualification, generator strobes and running match count
    always_comb begin
        sv_ok      = (sv_num != 6'd0) && (sv_num <= 6'd32);
        prn_d      = sv_num[4:0] - 5'd1;
        in_corr    = (state_q == ST_SEARCH) || (state_q == ST_TRACK);
        gen_reload = start && sv_ok;
        gen_adv    = !start && chip_valid && in_corr;
        match_d    = match_q + {10'd0, chip_in == local_chip};
        epoch_end  = (epoch_q == 10'(CA_LEN - 1));
    end

    gps_ca_gen u_gen (
        .clk_i     (sys_clk_50),
        .rst_i     (sync_rst_in),
        .reload_i  (gen_reload),
        .adv_i     (gen_adv),
        .prn_idx_i (prn_q),
        .chip_o    (local_chip)
    );

    // Acquisition FSM, epoch accumulation and result registers
    always_ff @(posedge sys_clk_50) begin
        if (sync_rst_in) begin
            state_q    <= ST_IDLE;
            prn_q      <= '0;
            epoch_q    <= '0;
            match_q    <= '0;
            slip_q     <= '0;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            phase_q    <= '0;
            corr_vld_q <= 1'b0;
            corr_cnt_q <= '0;
            fail_q     <= 1'b0;
        end else begin
            corr_vld_q <= 1'b0;
            fail_q     <= 1'b0;
            if (start) begin
                // Any start abandons the current search; the coincident chip is dropped
                epoch_q  <= '0;
                match_q  <= '0;
                slip_q   <= '0;
                locked_q <= 1'b0;
                phase_q  <= '0;
                if (sv_ok) begin
                    state_q <= ST_SEARCH;
                    prn_q   <= prn_d;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    fail_q  <= 1'b1;
                end
            end else if (chip_valid) begin
                case (state_q)
                    ST_SEARCH, ST_TRACK: begin
                        if (epoch_end) begin
                            epoch_q    <= '0;
                            match_q    <= '0;
                            corr_vld_q <= 1'b1;
                            corr_cnt_q <= match_d;
                            if (state_q == ST_SEARCH) begin
                                if (match_d >= 11'(LOCK_THRESH)) begin
                                    state_q  <= ST_TRACK;
                                    locked_q <= 1'b1;
                                end else begin
                                    state_q <= ST_SLIP;
                                end
                            end else if (match_d < 11'(LOSS_THRESH)) begin
                                state_q  <= ST_SLIP;
                                locked_q <= 1'b0;
                            end
                        end else begin
                            epoch_q <= epoch_q + 10'd1;
                            match_q <= match_d;
                        end
                    end
                    ST_SLIP: begin
                        // This chip is swallowed with the replica held: one chip of phase shift
                        phase_q <= (phase_q == 10'(CA_LEN - 1)) ? '0 : phase_q + 10'd1;
                        if (slip_q == 10'(MAX_SLIPS - 1)) begin
                            state_q  <= ST_IDLE;
                            busy_q   <= 1'b0;
                            locked_q <= 1'b0;
                            fail_q   <= 1'b1;
                        end else begin
                            slip_q  <= slip_q + 10'd1;
                            state_q <= ST_SEARCH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign locked      = locked_q;
    assign lock_phase  = phase_q;
    assign corr_valid  = corr_vld_q;
    assign corr_count  = corr_cnt_q;
    assign search_fail = fail_q;

endmodule
